// File: rtl/pipe_rx_fifo_if.sv
// Handshake bundle between an upstream producer, the receive FIFO and its consumer.
// The FIFO side takes the slave modport; the bench or surrounding logic takes master.
interface pipe_rx_fifo_if #(
    parameter int  Depth  = 4,
    parameter type data_t = logic
);
    localparam int CW = $clog2(Depth + 1);

    logic          valid_i;
    logic          ready_o;
    data_t         din;
    logic          valid_o;
    logic          ready_i;
    data_t         dout;
    logic [CW-1:0] count_o;
    logic          almost_full_o;

    modport slave (
        input  valid_i, din, ready_i,
        output ready_o, valid_o, dout, count_o, almost_full_o
    );

    modport master (
        output valid_i, din, ready_i,
        input  ready_o, valid_o, dout, count_o, almost_full_o
    );
endinterface

// File: rtl/pipe_rx_fifo.sv
// First-word-fall-through receive FIFO with occupancy count and almost-full flag.
// Handshake outputs depend only on registered state (and the async reset).
module pipe_rx_fifo #(
    parameter int  Depth  = 4,
    parameter type data_t = logic,
    parameter int  AfThr  = Depth - 1
) (
    input  logic         clk,
    input  logic         reset_n,
    pipe_rx_fifo_if.slave bus
);
    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth + 1);

    data_t         mem [Depth];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
    endfunction

    // reset_n gates ready_o so nothing is accepted while held in reset.
    always_comb begin
        bus.ready_o       = reset_n && (count < CW'(Depth));
        bus.valid_o       = (count != '0);
        bus.dout          = mem[rptr];
        bus.count_o       = count;
        bus.almost_full_o = (count >= CW'(AfThr));
    end

    assign push = bus.valid_i && bus.ready_o;
    assign pop  = bus.valid_o && bus.ready_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= bus.din;
                wptr      <= bump(wptr);
            end
            if (pop) rptr <= bump(rptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end
endmodule

// File: doc/pipe_rx_fifo.md
PIPE_RX_FIFO -- requirements
Module: pipe_rx_fifo

Interface
REQ-001 The block SHALL have parameter Depth, default 4, meaning number of storage entries (legal range 2..256; need not be a power of two).
REQ-002 The block SHALL have parameter data_t, default logic, meaning payload type carried on din/dout.
REQ-003 The block SHALL have parameter AfThr, default Depth-1, meaning the occupancy at or above which almost_full_o asserts (legal 1..Depth).
REQ-004 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port valid_i  input  1  upstream payload valid.
REQ-007 The block SHALL have port ready_o  output  1  block can accept a payload this cycle.
REQ-008 The block SHALL have port din  input  data_t  upstream payload.
REQ-009 The block SHALL have port valid_o  output  1  dout holds the oldest stored payload.
REQ-010 The block SHALL have port ready_i  input  1  downstream accepts dout this cycle.
REQ-011 The block SHALL have port dout  output  data_t  oldest stored payload (first-word-fall-through).
REQ-012 The block SHALL have port count_o  output  clog2(Depth+1)  current occupancy.
REQ-013 The block SHALL have port almost_full_o  output  1  count_o >= AfThr.

Function
REQ-014 The block SHALL define push = valid_i && ready_o and pop = valid_o && ready_i, both evaluated in the same cycle.
REQ-015 The block SHALL drive ready_o = (count_o < Depth) from registered state only, with no combinational path from ready_i or valid_i.
REQ-016 The block SHALL drive valid_o = (count_o != 0) from registered state only.
REQ-017 On push, the block SHALL write din to the entry at the write pointer and advance the write pointer by one, wrapping from Depth-1 to 0.
REQ-018 On pop, the block SHALL advance the read pointer by one, wrapping from Depth-1 to 0.
REQ-019 The block SHALL drive dout combinationally from the entry at the read pointer; there SHALL be no din-to-dout bypass.
REQ-020 The block SHALL update count_o as follows: push only +1; pop only -1; push and pop together unchanged; neither unchanged.
REQ-021 The block SHALL give a payload pushed at edge N valid_o=1 and dout=payload by the cycle following edge N when the FIFO was empty (one-cycle latency).
REQ-022 The block SHALL preserve strict FIFO order across pointer wrap-around for any Depth.
REQ-023 When full (count_o == Depth), the block SHALL hold ready_o=0 even if ready_i=1; the freed slot is advertised the cycle after the pop.
REQ-024 When empty, the block SHALL ignore ready_i; no pointer or count change occurs without push.
REQ-025 The block SHALL hold dout and valid_o stable while valid_o=1 and ready_i=0.
REQ-026 The block SHALL leave storage contents unchanged for entries not written by push.

Reset
REQ-027 While reset_n=0, the block SHALL force count_o=0, both pointers=0, valid_o=0, ready_o=0, almost_full_o=0, dout=0, immediately and independently of clk.
REQ-028 The block SHALL clear all storage entries to '0 on reset.
REQ-029 The block SHALL assert ready_o=1 in the first cycle after reset_n deasserts, and SHALL accept no push while reset_n=0.
REQ-030 Assertion of reset_n=0 mid-operation SHALL discard all stored payloads; no stale payload SHALL appear after release.

Verification
REQ-031 The bench SHALL verify (Depth=4): push 0xA1 with ready_i=0 -> next cycle valid_o=1, dout=0xA1, count_o=1.
REQ-032 The bench SHALL verify: push 0x01..0x04 with ready_i=0 -> count_o=4, ready_o=0, almost_full_o=1 from count 3; a valid_i=1 with din=0x05 is not stored.
REQ-033 The bench SHALL verify: when full, ready_i=1 for one cycle -> 0x01 popped, the next cycle ready_o=1, count_o=3, dout=0x02.
REQ-034 The bench SHALL verify: 10 cycles of continuous push and pop with count_o=2 -> count_o stays 2, outputs in order across pointer wrap.
REQ-035 The bench SHALL verify: reset_n pulled low between edges with 3 entries stored -> valid_o=0, count_o=0, dout=0 immediately; after release the first output is the first new push.
REQ-036 The bench SHALL verify with Depth=3: push 0x10..0x16 at random ready_i -> outputs 0x10..0x16 in order, with no loss and no duplication.
